// File: rtl/fetch_pair_buffer.sv
// Instruction queue between fetch and dual-issue decode.
// Stores per-instruction entries and presents the two oldest.
module fetch_pair_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fetch_valid_i,
  input  logic [63:0]                fetch_data_i,
  input  logic [31:0]                fetch_pc_i,
  output logic                       fetch_ready_o,
  input  logic                       flush_i,
  input  logic [1:0]                 issue_count_i,
  output logic [31:0]                inst0_o,
  output logic [31:0]                inst1_o,
  output logic [31:0]                pc0_o,
  output logic [31:0]                pc1_o,
  output logic                       valid0_o,
  output logic                       valid1_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            enq_go;
  logic [CW-1:0]   enq_n;
  logic [CW-1:0]   iss_c;
  logic [CW-1:0]   deq;
  logic [AW-1:0]   rd_ptr1;
  logic [AW-1:0]   wr_ptr1;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);

  assign fetch_ready_o = (count <= CW'(DEPTH - 2));
  assign enq_go = fetch_valid_i && fetch_ready_o && !flush_i;

  always_comb begin
    enq_n = '0;
    if (enq_go) begin
      enq_n = fetch_pc_i[2] ? CW'(1) : CW'(2);
    end
  end

  // issue_count_i of 3 saturates to 2; never retire more than held
  always_comb begin
    iss_c = (issue_count_i == 2'd3) ? CW'(2) : CW'(issue_count_i);
    deq   = (iss_c > count) ? count : iss_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + deq[AW-1:0];
      wr_ptr <= wr_ptr + enq_n[AW-1:0];
      count  <= count + enq_n - deq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_go) begin
      if (fetch_pc_i[2]) begin
        mem_q[wr_ptr] <= '{inst: fetch_data_i[63:32], pc: fetch_pc_i};
      end else begin
        mem_q[wr_ptr]  <= '{inst: fetch_data_i[31:0], pc: fetch_pc_i};
        mem_q[wr_ptr1] <= '{inst: fetch_data_i[63:32],
                            pc: fetch_pc_i + 32'd4};
      end
    end
  end

  assign valid0_o = (count >= CW'(1));
  assign valid1_o = (count >= CW'(2));
  assign count_o  = count;

  assign inst0_o = valid0_o ? mem_q[rd_ptr].inst  : NOP_INST;
  assign pc0_o   = valid0_o ? mem_q[rd_ptr].pc    : 32'd0;
  assign inst1_o = valid1_o ? mem_q[rd_ptr1].inst : NOP_INST;
  assign pc1_o   = valid1_o ? mem_q[rd_ptr1].pc   : 32'd0;

  count_le_depth: assert property (
    @(posedge clk_i) disable iff (rst_i) count <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Random and directed bench for fetch_pair_buffer
// against a queue-based reference model.
module tb_fetch_pair_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_valid_i = 1'b0;
  logic [63:0] fetch_data_i = '0;
  logic [31:0] fetch_pc_i = '0;
  logic        fetch_ready_o;
  logic        flush_i = 1'b0;
  logic [1:0]  issue_count_i = '0;
  logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;
  logic        valid0_o, valid1_o;
  logic [3:0]  count_o;

  int checks = 0;
  int failures = 0;

  fetch_pair_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_valid_i(fetch_valid_i), .fetch_data_i(fetch_data_i),
    .fetch_pc_i(fetch_pc_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .issue_count_i(issue_count_i),
    .inst0_o(inst0_o), .inst1_o(inst1_o),
    .pc0_o(pc0_o), .pc1_o(pc1_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue, oldest at the front
  always @(posedge clk_i or posedge rst_i) begin
    int n, d;
    bit rdy;
    if (rst_i || flush_i) begin
      mq.delete();
    end else begin
      n = mq.size();
      rdy = (n <= DEPTH - 2);
      d = (issue_count_i == 2'd3) ? 2 : int'(issue_count_i);
      if (d > n) d = n;
      repeat (d) void'(mq.pop_front());
      if (fetch_valid_i && rdy) begin
        if (fetch_pc_i[2]) begin
          mq.push_back({fetch_data_i[63:32], fetch_pc_i});
        end else begin
          mq.push_back({fetch_data_i[31:0], fetch_pc_i});
          mq.push_back({fetch_data_i[63:32], fetch_pc_i + 32'd4});
        end
      end
    end
  end

  always @(negedge clk_i) begin
    int n;
    n = mq.size();
    chk("count", 32'(count_o), 32'(n));
    chk("ready", 32'(fetch_ready_o), 32'(n <= DEPTH - 2));
    chk("valid0", 32'(valid0_o), 32'(n >= 1));
    chk("valid1", 32'(valid1_o), 32'(n >= 2));
    chk("inst0", inst0_o, (n >= 1) ? mq[0].inst : NOP);
    chk("pc0", pc0_o, (n >= 1) ? mq[0].pc : 32'd0);
    chk("inst1", inst1_o, (n >= 2) ? mq[1].inst : NOP);
    chk("pc1", pc1_o, (n >= 2) ? mq[1].pc : 32'd0);
  end

  task automatic cyc(bit fv, logic [63:0] d, logic [31:0] pc,
                     logic [1:0] iss, bit fl);
    fetch_valid_i = fv;
    fetch_data_i  = d;
    fetch_pc_i    = pc;
    issue_count_i = iss;
    flush_i       = fl;
    @(posedge clk_i);
    #1;
    fetch_valid_i = 1'b0;
    issue_count_i = 2'd0;
    flush_i       = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_inst0", inst0_o, NOP);
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    rst_i = 1'b0;

    cyc(1, {32'hBBBB0002, 32'hAAAA0001}, 32'h100, 0, 0);
    chk("t1_inst0", inst0_o, 32'hAAAA0001);
    chk("t1_pc0", pc0_o, 32'h100);
    chk("t1_inst1", inst1_o, 32'hBBBB0002);
    chk("t1_pc1", pc1_o, 32'h104);
    chk("t1_count", 32'(count_o), 32'd2);
    cyc(0, '0, '0, 2, 0);
    chk("t1_drain_count", 32'(count_o), 32'd0);
    chk("t1_drain_inst0", inst0_o, NOP);

    cyc(1, {32'hCCCC0003, 32'hDEADBEEF}, 32'h104, 0, 0);
    chk("t2_inst0", inst0_o, 32'hCCCC0003);
    chk("t2_pc0", pc0_o, 32'h104);
    chk("t2_valid1", 32'(valid1_o), 32'd0);
    chk("t2_count", 32'(count_o), 32'd1);
    cyc(0, '0, '0, 1, 0);

    for (int i = 0; i < 4; i++)
      cyc(1, {32'h5000_0000 + 32'(2*i+1), 32'h5000_0000 + 32'(2*i)},
          32'h200 + 32'(8*i), 0, 0);
    chk("t3_count", 32'(count_o), 32'd8);
    chk("t3_ready", 32'(fetch_ready_o), 32'd0);
    cyc(1, {32'h6666_0001, 32'h6666_0000}, 32'h220, 0, 0);
    chk("t3_full_count", 32'(count_o), 32'd8);
    chk("t3_head", inst0_o, 32'h5000_0000);

    cyc(0, '0, '0, 2, 0);
    chk("t4_pre", 32'(count_o), 32'd6);
    cyc(1, {32'h7777_0001, 32'h7777_0000}, 32'h300, 1, 0);
    chk("t4_count", 32'(count_o), 32'd7);
    chk("t4_head", inst0_o, 32'h5000_0003);
    for (int i = 0; i < 4; i++) cyc(0, '0, '0, 2, 0);

    cyc(0, '0, '0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, {32'h8000_0000 + 32'(2*i+1), 32'h8000_0000 + 32'(2*i)},
          32'h400 + 32'(8*i), 0, 0);
    cyc(1, {32'h8000_0006, 32'h0}, 32'h41C, 2, 0);
    cyc(0, '0, '0, 2, 0);
    cyc(0, '0, '0, 2, 0);
    cyc(0, '0, '0, 1, 0);
    chk("t5_pre_count", 32'(count_o), 32'd0);
    cyc(1, {32'h9999_0001, 32'h9999_0000}, 32'h500, 0, 0);
    chk("t5_inst0", inst0_o, 32'h9999_0000);
    chk("t5_inst1", inst1_o, 32'h9999_0001);
    chk("t5_pc1", pc1_o, 32'h504);
    cyc(0, '0, '0, 2, 0);
    chk("t5_count", 32'(count_o), 32'd0);

    cyc(1, {32'hA1, 32'hA0}, 32'h600, 0, 0);
    cyc(1, {32'hA3, 32'hA2}, 32'h608, 0, 0);
    cyc(1, {32'hA5, 32'hA4}, 32'h614, 0, 0);
    chk("t6_pre", 32'(count_o), 32'd5);
    cyc(1, {32'hB1, 32'hB0}, 32'h618, 2, 1);
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_valid0", 32'(valid0_o), 32'd0);
    cyc(0, '0, '0, 0, 0);
    chk("t6_nostore", 32'(count_o), 32'd0);

    cyc(1, {32'hC1, 32'hC0}, 32'h700, 0, 0);
    cyc(1, {32'hC3, 32'hC2}, 32'h708, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("t7_rst_count", 32'(count_o), 32'd0);
    chk("t7_rst_valid0", 32'(valid0_o), 32'd0);
    chk("t7_rst_inst1", inst1_o, NOP);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) begin
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
      end else begin
        cyc(bit'($urandom_range(3) != 0),
            {$urandom(), $urandom()},
            {$urandom_range(32'h3FFF_FFFF), 2'b00},
            2'($urandom_range(3)),
            bit'($urandom_range(29) == 0));
      end
    end

    @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
